// File: rtl/ddr_axi_arb_pkg.sv
// Shared types and the round-robin pick function for the DDR AXI read arbiter.
// No logic of its own; t_ar_if field widths follow the arbiter's default parameters.
// The arbiter top takes its ID_WIDTH/ADDR_WIDTH defaults from here, so the two stay in step.
package ddr_axi_arb_pkg;

  localparam int NUM_REQ        = 2;
  localparam int ARB_ID_WIDTH   = 5;   // requester-side ID width
  localparam int ARB_ADDR_WIDTH = 34;

  // One AR request as held in the output stage; id carries the requester tag in its MSB.
  typedef struct packed {
    logic [ARB_ID_WIDTH:0]     id;
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
  } t_ar_if;

  // Returns the winning requester index. With both eligible the one not granted
  // last time wins; with a single eligible requester it wins. Callers must only
  // use the result when at least one requester is eligible.
  function automatic logic rr_pick(input logic last, input logic [NUM_REQ-1:0] elig);
    logic pick;
    if (&elig) pick = ~last;
    else       pick = elig[1];
    return pick;
  endfunction

endpackage

// File: rtl/ddr_axi_pend_cnt.sv
// Purpose : per-requester count of outstanding read bursts, saturating at 0 and MAX_PENDING.
// Latency : cnt_o/full_o are registered; they reflect inc/dec one cycle after the edge.
// Backpr. : none; full_o is what the arbiter uses to hold off further AR grants.
// Ports   : clk, rst (sync, active-high), inc_i (AR accepted), dec_i (last R beat
//           accepted), cnt_o (current count), full_o (count == MAX_PENDING).
module ddr_axi_pend_cnt #(
  parameter int MAX_PENDING = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc_i,
  input  logic                         dec_i,
  output logic [$clog2(MAX_PENDING):0] cnt_o,
  output logic                         full_o
);

  localparam int CNT_W = $clog2(MAX_PENDING) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({inc_i, dec_i})
      2'b10:   if (cnt_q != MAX_CNT) cnt_d = cnt_q + CNT_W'(1);
      2'b01:   if (cnt_q != '0)      cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;  // idle, or inc and dec cancelling out
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == MAX_CNT);

`ifndef SYNTHESIS
  // An rlast for a requester with nothing outstanding means the DDR side returned
  // a burst we never issued (or tracking was lost by a one-sided reset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(dec_i && (cnt_q == '0)))
        else $error("ddr_axi_pend_cnt: rlast received with no burst outstanding");
    end
  end
`endif

endmodule

// File: rtl/ddr_axi_rd_arbiter.sv
// Purpose : shares one DDR AXI read port between two requesters; round-robin AR, R routed by ARID MSB.
// Latency : AR 1 cycle (single registered stage, one AR per cycle sustained); R 0 cycles (combinational).
// Backpr. : m_arready stall holds the stage and drops both s*_arready; R ready follows the addressed requester.
// Ports   : clk, rst (sync, active-high); s0_ar*/s1_ar* requester AR inputs with s*_arready;
//           s0_r*/s1_r* requester R outputs with s*_rready; m_ar*/m_r* DDR-side AXI read channels;
//           idle high when nothing is outstanding or staged.
// Option  : define DDR_RD_ARB_STATS_EN to add s0_grant_cnt, s1_grant_cnt and stall_cnt.
module ddr_axi_rd_arbiter
  import ddr_axi_arb_pkg::*;
#(
  parameter int ID_WIDTH    = ARB_ID_WIDTH,
  parameter int ADDR_WIDTH  = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = 1024,
  parameter int MAX_PENDING = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0 AR
  input  logic                  s0_arvalid,
  input  logic [ID_WIDTH-1:0]   s0_arid,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  output logic                  s0_arready,
  // requester 1 AR
  input  logic                  s1_arvalid,
  input  logic [ID_WIDTH-1:0]   s1_arid,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  output logic                  s1_arready,
  // requester 0 R
  output logic                  s0_rvalid,
  output logic [ID_WIDTH-1:0]   s0_rid,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  input  logic                  s0_rready,
  // requester 1 R
  output logic                  s1_rvalid,
  output logic [ID_WIDTH-1:0]   s1_rid,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  input  logic                  s1_rready,
  // DDR AR
  output logic                  m_arvalid,
  output logic [ID_WIDTH:0]     m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_arready,
  // DDR R
  input  logic                  m_rvalid,
  input  logic [ID_WIDTH:0]     m_rid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  m_rready,
`ifdef DDR_RD_ARB_STATS_EN
  output logic [31:0]           s0_grant_cnt,
  output logic [31:0]           s1_grant_cnt,
  output logic [31:0]           stall_cnt,
`endif
  output logic                  idle
);

  localparam int CNT_W = $clog2(MAX_PENDING) + 1;

  t_ar_if           ar_q, ar_d;
  logic             m_arvalid_q, m_arvalid_d;
  logic             last_grant_q, last_grant_d;

  logic [CNT_W-1:0] pend0_cnt, pend1_cnt;
  logic             pend0_full, pend1_full;

  logic             stage_free;
  logic             elig0, elig1;
  logic             any_grant, pick;
  logic             grant0, grant1;

  logic             r_sel, r_last_hs;
  logic             dec0, dec1;

  // ---------------------------------------------------------------- AR arbitration
  // The stage can take a new entry when empty or when its entry leaves this cycle,
  // which is what allows one AR per cycle through a single register.
  assign stage_free = ~m_arvalid_q | m_arready;

  assign elig0 = s0_arvalid & ~pend0_full;
  assign elig1 = s1_arvalid & ~pend1_full;

  assign any_grant = ~rst & stage_free & (elig0 | elig1);
  assign pick      = rr_pick(last_grant_q, {elig1, elig0});
  assign grant0    = any_grant & ~pick;
  assign grant1    = any_grant &  pick;

  assign s0_arready = grant0;
  assign s1_arready = grant1;

  always_comb begin
    ar_d         = ar_q;
    m_arvalid_d  = m_arvalid_q;
    last_grant_d = last_grant_q;
    if (any_grant) begin
      m_arvalid_d  = 1'b1;
      last_grant_d = pick;
      if (pick) begin
        ar_d.id    = {1'b1, s1_arid};
        ar_d.addr  = s1_araddr;
        ar_d.len   = s1_arlen;
        ar_d.size  = s1_arsize;
        ar_d.burst = s1_arburst;
      end else begin
        ar_d.id    = {1'b0, s0_arid};
        ar_d.addr  = s0_araddr;
        ar_d.len   = s0_arlen;
        ar_d.size  = s0_arsize;
        ar_d.burst = s0_arburst;
      end
    end else if (stage_free) begin
      m_arvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q         <= '0;
      m_arvalid_q  <= 1'b0;
      last_grant_q <= 1'b1;  // makes s0 the first winner out of reset
    end else begin
      ar_q         <= ar_d;
      m_arvalid_q  <= m_arvalid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign m_arvalid = m_arvalid_q;
  assign m_arid    = ar_q.id;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = ar_q.burst;

  // ---------------------------------------------------------------- R routing
  assign r_sel = m_rid[ID_WIDTH];

  assign s0_rvalid = m_rvalid & ~r_sel;
  assign s1_rvalid = m_rvalid &  r_sel;
  assign s0_rid    = m_rid[ID_WIDTH-1:0];
  assign s1_rid    = m_rid[ID_WIDTH-1:0];
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign m_rready  = r_sel ? s1_rready : s0_rready;

  // A burst retires only when its last beat is actually accepted upstream.
  assign r_last_hs = m_rvalid & m_rready & m_rlast;
  assign dec0      = r_last_hs & ~r_sel;
  assign dec1      = r_last_hs &  r_sel;

  // ---------------------------------------------------------------- pending budgets
  ddr_axi_pend_cnt #(.MAX_PENDING(MAX_PENDING)) u_pend0 (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (grant0),
    .dec_i  (dec0),
    .cnt_o  (pend0_cnt),
    .full_o (pend0_full)
  );

  ddr_axi_pend_cnt #(.MAX_PENDING(MAX_PENDING)) u_pend1 (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (grant1),
    .dec_i  (dec1),
    .cnt_o  (pend1_cnt),
    .full_o (pend1_full)
  );

  assign idle = (pend0_cnt == '0) & (pend1_cnt == '0) & ~m_arvalid_q;

  // ---------------------------------------------------------------- optional statistics
`ifdef DDR_RD_ARB_STATS_EN
  logic [31:0] s0_grant_cnt_q, s1_grant_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_grant_cnt_q <= '0;
      s1_grant_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (grant0 && (s0_grant_cnt_q != '1)) s0_grant_cnt_q <= s0_grant_cnt_q + 32'd1;
      if (grant1 && (s1_grant_cnt_q != '1)) s1_grant_cnt_q <= s1_grant_cnt_q + 32'd1;
      if (m_arvalid_q && !m_arready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign s0_grant_cnt = s0_grant_cnt_q;
  assign s1_grant_cnt = s1_grant_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule
